rename_stage_ctrl: RTL and testbench
====================================

Name: rename_stage_ctrl

Overview:
Controls the rename pipeline stage. It sits between decode and dispatch and sequences each decoded instruction through the arch→physical rename table, which holds the mapping array and the free-PRF FIFO. Renaming fires only when a free physical register is available and the downstream slot can accept the result. The block also owns stall and flush sequencing, and registers the renamed operands toward dispatch.

Parameters:
ARCH_REG_NUM_WIDTH, 5, bits of architectural register index
PHYSICAL_REG_NUM_WIDTH, 6, bits of physical register index
FLUSH_WAIT_CYCLES, 4, cycles rename is blocked after flush for table recovery (≥1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dec_valid  in  1  decode holds an instruction
dec_ready  out  1  controller accepts decode instruction this cycle
dec_rs1  in  ARCH_REG_NUM_WIDTH  source 1 arch reg
dec_rs2  in  ARCH_REG_NUM_WIDTH  source 2 arch reg
dec_rd  in  ARCH_REG_NUM_WIDTH  destination arch reg
dec_regwrite  in  1  instruction writes rd
rt_read_reg_num1  out  ARCH_REG_NUM_WIDTH  to rename table
rt_read_reg_num2  out  ARCH_REG_NUM_WIDTH  to rename table
rt_write_reg_num  out  ARCH_REG_NUM_WIDTH  to rename table
rt_regwrite  out  1  allocate new PRF (pops free list)
rt_phy_rs1  in  PHYSICAL_REG_NUM_WIDTH  mapped source 1
rt_phy_rs2  in  PHYSICAL_REG_NUM_WIDTH  mapped source 2
rt_phy_rd  in  PHYSICAL_REG_NUM_WIDTH  newly allocated dest
rt_valid  in  1  free list non-empty
flush  in  1  pipeline flush pulse
dsp_valid  out  1  renamed instruction available
dsp_ready  in  1  dispatch accepts
dsp_prs1  out  PHYSICAL_REG_NUM_WIDTH  renamed source 1
dsp_prs2  out  PHYSICAL_REG_NUM_WIDTH  renamed source 2
dsp_prd  out  PHYSICAL_REG_NUM_WIDTH  renamed dest (0 if no write)
dsp_regwrite  out  1  renamed instruction writes
busy  out  1  state != RUN
perf_rename_cnt  out  32  instructions renamed (see optional feature)
perf_stall_cnt  out  32  cycles in STALL (see optional feature)

Behaviour:
- Reset: clk, reset asynchronous active-high. All outputs 0, state=RUN, flush counter 0, output register empty.
- rt_read_reg_num1/2 and rt_write_reg_num are driven combinationally from dec_rs1/rs2/rd at all times.
- need_alloc = dec_regwrite && dec_rd != 0. x0 never allocates.
- out_free = !dsp_valid || dsp_ready.
- dec_ready = state==RUN && !flush && out_free && (!need_alloc || rt_valid). dec_ready may depend on decode payload.
- fire = dec_valid && dec_ready.
- rt_regwrite = fire && need_alloc, combinational, same cycle as fire. This is the only free-list pop source.
- On fire, the output register captures rt_phy_rs1, rt_phy_rs2, rt_phy_rd (or 0 when !need_alloc) and need_alloc→dsp_regwrite. dsp_valid=1 next cycle. Latency is 1 cycle.
- dsp_valid && dsp_ready without fire: dsp_valid clears next cycle. Fire with dsp_ready in the same cycle: back-to-back, one instruction per cycle.
- Output payload holds stable while dsp_valid && !dsp_ready.
- FSM:
  - RUN → STALL when dec_valid && need_alloc && !rt_valid && !flush.
  - STALL → RUN when rt_valid=1. Fire is possible in that same cycle, since dec_ready is evaluated with state==STALL treated as RUN once rt_valid is set.
  - STALL → RUN also when dec_valid drops.
  - any → FLUSH on flush. The counter loads FLUSH_WAIT_CYCLES-1.
  - FLUSH: counter decrements each cycle. Go to RUN when the counter is 0 and flush=0. flush during FLUSH reloads the counter.
- Flush priority:
  - In the flush cycle: no fire, rt_regwrite=0, dsp_valid cleared next cycle regardless of dsp_ready.
  - dec_ready=0 for exactly FLUSH_WAIT_CYCLES cycles after a single-cycle flush pulse.
- Reset mid-operation: immediate return to reset values. Any in-flight output is discarded.

Optional Feature:
- Macro: RENAME_PERF_CNT_EN.
- Defined:
  - perf_rename_cnt increments on each fire.
  - perf_stall_cnt increments each cycle state==STALL.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by reset only (not by flush).
- Undefined: both ports tied to constant 0. No counter flops.

Test Plan:
- Reset, dec_valid=1, rd=3, regwrite=1, rt_valid=1, rt_phy_rd=33, dsp_ready=1 → rt_regwrite=1 in cycle 0. Cycle 1: dsp_valid=1, dsp_prd=33, dsp_regwrite=1.
- rd=0, regwrite=1 → rt_regwrite=0, dsp_prd=0, dsp_regwrite=0. Accepted even with rt_valid=0.
- need_alloc with rt_valid=0 for 3 cycles, then 1 → busy=1 for 3 cycles, perf_stall_cnt=3 (macro on), fire in the cycle rt_valid rises.
- dsp_ready=0 with 2 queued decode instructions → first held stable in output, dec_ready=0. dsp_ready=1 → back-to-back output, one per cycle.
- flush pulse while dsp_valid=1, FLUSH_WAIT_CYCLES=4 → dsp_valid=0 next cycle. dec_ready=0 for 4 cycles. Second flush in cycle 2 extends the block to 4 cycles after it.
- Assert reset during STALL with dsp_valid=1 → all outputs 0 immediately, state RUN, counters 0.

Source files
------------

// File: rtl/rename_stage_ctrl_if.sv
// Decode, rename-table and dispatch bundle around the rename stage controller.
// The slave modport is the controller's view and the master modport is the surrounding pipeline's view.
interface rename_stage_ctrl_if #(
  parameter int ARCH_REG_NUM_WIDTH     = 5,
  parameter int PHYSICAL_REG_NUM_WIDTH = 6
);
  logic                              dec_valid;
  logic                              dec_ready;
  logic [ARCH_REG_NUM_WIDTH-1:0]     dec_rs1;
  logic [ARCH_REG_NUM_WIDTH-1:0]     dec_rs2;
  logic [ARCH_REG_NUM_WIDTH-1:0]     dec_rd;
  logic                              dec_regwrite;

  logic [ARCH_REG_NUM_WIDTH-1:0]     rt_read_reg_num1;
  logic [ARCH_REG_NUM_WIDTH-1:0]     rt_read_reg_num2;
  logic [ARCH_REG_NUM_WIDTH-1:0]     rt_write_reg_num;
  logic                              rt_regwrite;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] rt_phy_rs1;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] rt_phy_rs2;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] rt_phy_rd;
  logic                              rt_valid;

  logic                              dsp_valid;
  logic                              dsp_ready;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] dsp_prs1;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] dsp_prs2;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] dsp_prd;
  logic                              dsp_regwrite;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_regwrite,
    output dec_ready,
    output rt_read_reg_num1, rt_read_reg_num2, rt_write_reg_num, rt_regwrite,
    input  rt_phy_rs1, rt_phy_rs2, rt_phy_rd, rt_valid,
    output dsp_valid, dsp_prs1, dsp_prs2, dsp_prd, dsp_regwrite,
    input  dsp_ready
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_regwrite,
    input  dec_ready,
    input  rt_read_reg_num1, rt_read_reg_num2, rt_write_reg_num, rt_regwrite,
    output rt_phy_rs1, rt_phy_rs2, rt_phy_rd, rt_valid,
    input  dsp_valid, dsp_prs1, dsp_prs2, dsp_prd, dsp_regwrite,
    output dsp_ready
  );
endinterface

// File: rtl/rename_stage_ctrl.sv
// Rename stage controller: gates decode into the rename table, owns stall/flush sequencing and the dispatch output register.
// Optional performance counters are enabled by defining RENAME_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal renaming
// STALL | decode waits for a free physical register
// FLUSH | table recovery after flush, rename blocked until counter drains
module rename_stage_ctrl #(
  parameter int ARCH_REG_NUM_WIDTH     = 5,
  parameter int PHYSICAL_REG_NUM_WIDTH = 6,
  parameter int FLUSH_WAIT_CYCLES      = 4
) (
  input  logic                clk,
  input  logic                reset,
  rename_stage_ctrl_if.slave  bus,
  input  logic                flush,
  output logic                busy,
  output logic [31:0]         perf_rename_cnt,
  output logic [31:0]         perf_stall_cnt
);

  localparam int CNT_WIDTH = $clog2(FLUSH_WAIT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD = CNT_WIDTH'(FLUSH_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

  logic                        dsp_valid_q;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] prs1_q, prs2_q, prd_q;
  logic                        regwrite_q;

  logic need_alloc;
  logic out_free;
  logic run_eff;
  logic dec_ready;
  logic fire;

  assign bus.rt_read_reg_num1 = bus.dec_rs1;
  assign bus.rt_read_reg_num2 = bus.dec_rs2;
  assign bus.rt_write_reg_num = bus.dec_rd;

  always_comb begin
    need_alloc = bus.dec_regwrite && (bus.dec_rd != '0);
    out_free   = !dsp_valid_q || bus.dsp_ready;
    // STALL behaves like RUN in the cycle the free list recovers, so the waiting instruction fires immediately
    run_eff    = (state_q == S_RUN) || ((state_q == S_STALL) && bus.rt_valid);
    dec_ready  = !reset && run_eff && !flush && out_free && (!need_alloc || bus.rt_valid);
    fire       = bus.dec_valid && dec_ready;
  end

  assign bus.dec_ready   = dec_ready;
  assign bus.rt_regwrite = fire && need_alloc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = (state_q != S_RUN);
    if (flush) begin
      state_d = S_FLUSH;
      cnt_d   = FLUSH_LOAD;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.dec_valid && need_alloc && !bus.rt_valid) state_d = S_STALL;
        end
        S_STALL: begin
          if (bus.rt_valid || !bus.dec_valid) state_d = S_RUN;
        end
        S_FLUSH: begin
          if (cnt_q == '0) state_d = S_RUN;
          else             cnt_d   = cnt_q - CNT_WIDTH'(1);
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Flush wins over both capture and drain; the payload is zeroed with it so a dropped entry leaves no residue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_valid_q <= 1'b0;
      prs1_q      <= '0;
      prs2_q      <= '0;
      prd_q       <= '0;
      regwrite_q  <= 1'b0;
    end else if (flush) begin
      dsp_valid_q <= 1'b0;
      prs1_q      <= '0;
      prs2_q      <= '0;
      prd_q       <= '0;
      regwrite_q  <= 1'b0;
    end else if (fire) begin
      dsp_valid_q <= 1'b1;
      prs1_q      <= bus.rt_phy_rs1;
      prs2_q      <= bus.rt_phy_rs2;
      prd_q       <= need_alloc ? bus.rt_phy_rd : '0;
      regwrite_q  <= need_alloc;
    end else if (bus.dsp_ready) begin
      dsp_valid_q <= 1'b0;
    end
  end

  assign bus.dsp_valid    = dsp_valid_q;
  assign bus.dsp_prs1     = prs1_q;
  assign bus.dsp_prs2     = prs2_q;
  assign bus.dsp_prd      = prd_q;
  assign bus.dsp_regwrite = regwrite_q;

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] rename_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rename_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (fire && (rename_cnt_q != '1)) rename_cnt_q <= rename_cnt_q + 32'd1;
      if ((state_q == S_STALL) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_rename_cnt = rename_cnt_q;
  assign perf_stall_cnt  = stall_cnt_q;
`else
  assign perf_rename_cnt = '0;
  assign perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_rename_stage_ctrl.sv
// Self-checking bench for rename_stage_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a cycle-indexed behavioural model.
module tb_rename_stage_ctrl;
  localparam int AW = 5;
  localparam int PW = 6;
  localparam int W  = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        busy;
  logic [31:0] perf_rename_cnt;
  logic [31:0] perf_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  rename_stage_ctrl_if #(.ARCH_REG_NUM_WIDTH(AW), .PHYSICAL_REG_NUM_WIDTH(PW)) bus ();

  rename_stage_ctrl #(
    .ARCH_REG_NUM_WIDTH(AW), .PHYSICAL_REG_NUM_WIDTH(PW), .FLUSH_WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush(flush), .busy(busy),
    .perf_rename_cnt(perf_rename_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit dv, input int rd, input bit rw, input int prd, input bit rtv, input bit dr);
    bus.dec_valid    = dv;
    bus.dec_rd       = AW'(rd);
    bus.dec_regwrite = rw;
    bus.rt_phy_rd    = PW'(prd);
    bus.rt_valid     = rtv;
    bus.dsp_ready    = dr;
  endtask

  task automatic count_block(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.dec_ready) break;
      n++;
      step();
    end
  endtask

  // Behavioural model: an output slot, a "waiting for free register" flag, and the cycle of the latest flush
  bit                m_dv, m_rw, m_stalled;
  logic [PW-1:0]     m_prs1, m_prs2, m_prd;
  int                cyc, last_flush;
  logic [31:0]       m_rc, m_sc;

  initial begin
    bit need, blocked, free_slot, in_run, e_ready, e_fire;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_dsp_valid", 32'(bus.dsp_valid), 0);
        chk("rst_dec_ready", 32'(bus.dec_ready), 0);
        chk("rst_rt_regwrite", 32'(bus.rt_regwrite), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perf_rename", perf_rename_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);
        m_dv = 0; m_rw = 0; m_stalled = 0;
        m_prs1 = '0; m_prs2 = '0; m_prd = '0;
        cyc = 0; last_flush = -100; m_rc = 0; m_sc = 0;
      end else begin
        need      = bus.dec_regwrite && (bus.dec_rd != 0);
        blocked   = (cyc - last_flush) <= W;
        free_slot = !m_dv || bus.dsp_ready;
        in_run    = !blocked && (!m_stalled || bus.rt_valid);
        e_ready   = in_run && !flush && free_slot && (!need || bus.rt_valid);
        e_fire    = bus.dec_valid && e_ready;

        chk("rd_num1", 32'(bus.rt_read_reg_num1), 32'(bus.dec_rs1));
        chk("rd_num2", 32'(bus.rt_read_reg_num2), 32'(bus.dec_rs2));
        chk("wr_num", 32'(bus.rt_write_reg_num), 32'(bus.dec_rd));
        chk("dec_ready", 32'(bus.dec_ready), 32'(e_ready));
        chk("rt_regwrite", 32'(bus.rt_regwrite), 32'(e_fire && need));
        chk("busy", 32'(busy), 32'(blocked || m_stalled));
        chk("dsp_valid", 32'(bus.dsp_valid), 32'(m_dv));
        if (m_dv) begin
          chk("dsp_prs1", 32'(bus.dsp_prs1), 32'(m_prs1));
          chk("dsp_prs2", 32'(bus.dsp_prs2), 32'(m_prs2));
          chk("dsp_prd", 32'(bus.dsp_prd), 32'(m_prd));
          chk("dsp_regwrite", 32'(bus.dsp_regwrite), 32'(m_rw));
        end
`ifdef RENAME_PERF_CNT_EN
        chk("perf_rename", perf_rename_cnt, m_rc);
        chk("perf_stall", perf_stall_cnt, m_sc);
`else
        chk("perf_rename", perf_rename_cnt, 0);
        chk("perf_stall", perf_stall_cnt, 0);
`endif
        if (e_fire) m_rc++;
        if (m_stalled) m_sc++;
        if (flush) begin
          last_flush = cyc;
          m_dv = 0;
          m_stalled = 0;
        end else begin
          if (m_stalled) begin
            if (bus.rt_valid || !bus.dec_valid) m_stalled = 0;
          end else if (!blocked && bus.dec_valid && need && !bus.rt_valid) begin
            m_stalled = 1;
          end
          if (e_fire) begin
            m_dv   = 1;
            m_prs1 = bus.rt_phy_rs1;
            m_prs2 = bus.rt_phy_rs2;
            m_prd  = need ? bus.rt_phy_rd : '0;
            m_rw   = need;
          end else if (bus.dsp_ready) begin
            m_dv = 0;
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; flush = 1'b0;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    bus.rt_phy_rs1 = '0; bus.rt_phy_rs2 = '0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Simple allocate: pops in the fire cycle, appears one cycle later
    bus.dec_rs1 = 5'd1; bus.dec_rs2 = 5'd2;
    bus.rt_phy_rs1 = 6'd10; bus.rt_phy_rs2 = 6'd11;
    drive(1, 3, 1, 33, 1, 1);
    @(negedge clk);
    chk("t1_rt_regwrite", 32'(bus.rt_regwrite), 1);
    chk("t1_dsp_valid_before", 32'(bus.dsp_valid), 0);
    step(); drive(0, 3, 1, 33, 1, 1);
    @(negedge clk);
    chk("t1_dsp_valid", 32'(bus.dsp_valid), 1);
    chk("t1_dsp_prd", 32'(bus.dsp_prd), 33);
    chk("t1_dsp_prs1", 32'(bus.dsp_prs1), 10);
    chk("t1_dsp_regwrite", 32'(bus.dsp_regwrite), 1);

    // x0 destination never allocates and is accepted with an empty free list
    step(); drive(1, 0, 1, 44, 0, 1);
    @(negedge clk);
    chk("t2_dec_ready", 32'(bus.dec_ready), 1);
    chk("t2_rt_regwrite", 32'(bus.rt_regwrite), 0);
    step(); drive(0, 0, 1, 44, 0, 1);
    @(negedge clk);
    chk("t2_dsp_prd", 32'(bus.dsp_prd), 0);
    chk("t2_dsp_regwrite", 32'(bus.dsp_regwrite), 0);

    // Stall three cycles, fire when the free list recovers
    step(); drive(1, 5, 1, 20, 0, 1);
    @(negedge clk);
    chk("t3_busy_c0", 32'(busy), 0);
    chk("t3_ready_c0", 32'(bus.dec_ready), 0);
    for (int i = 1; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("t3_busy_stall", 32'(busy), 1);
    end
    step(); drive(1, 5, 1, 20, 1, 1);
    @(negedge clk);
    chk("t3_busy_c3", 32'(busy), 1);
    chk("t3_fire", 32'(bus.rt_regwrite), 1);
    step(); drive(0, 5, 1, 20, 1, 1);
    @(negedge clk);
    chk("t3_busy_after", 32'(busy), 0);
    chk("t3_dsp_prd", 32'(bus.dsp_prd), 20);
`ifdef RENAME_PERF_CNT_EN
    chk("t3_perf_stall", perf_stall_cnt, 3);
    chk("t3_perf_rename", perf_rename_cnt, 3);
`else
    chk("t3_perf_stall", perf_stall_cnt, 0);
`endif

    // Backpressure holds the first result, then back-to-back drain
    step(); drive(1, 6, 1, 21, 1, 0);
    @(negedge clk);
    chk("t4_fire_a", 32'(bus.rt_regwrite), 1);
    step(); drive(1, 7, 1, 22, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_ready_held", 32'(bus.dec_ready), 0);
      chk("t4_prd_held", 32'(bus.dsp_prd), 21);
      step();
    end
    drive(1, 7, 1, 22, 1, 1);
    @(negedge clk);
    chk("t4_ready_b2b", 32'(bus.dec_ready), 1);
    chk("t4_prd_first", 32'(bus.dsp_prd), 21);
    step(); drive(0, 7, 1, 22, 1, 1);
    @(negedge clk);
    chk("t4_valid_second", 32'(bus.dsp_valid), 1);
    chk("t4_prd_second", 32'(bus.dsp_prd), 22);

    // Flush drops the output and blocks decode for W cycles
    step(); drive(1, 8, 1, 23, 1, 0);
    step(); drive(0, 8, 1, 23, 1, 0); flush = 1'b1;
    @(negedge clk);
    chk("t5_valid_at_flush", 32'(bus.dsp_valid), 1);
    chk("t5_ready_at_flush", 32'(bus.dec_ready), 0);
    step(); flush = 1'b0; drive(1, 0, 1, 0, 1, 1);
    @(negedge clk);
    chk("t5_valid_dropped", 32'(bus.dsp_valid), 0);
    count_block(n);
    chk("t5_block_cycles", 32'(n + 1), W);

    // A second flush two cycles into the window restarts the full wait
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    count_block(n);
    chk("t5_reflush_block", 32'(n), W);

    // Reset while stalled with a pending output
    step(); drive(1, 10, 1, 25, 0, 0);
    step();
    #2;
    chk("t6_busy_pre", 32'(busy), 1);
    chk("t6_valid_pre", 32'(bus.dsp_valid), 1);
    reset = 1'b1;
    #1;
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_valid_rst", 32'(bus.dsp_valid), 0);
    chk("t6_prd_rst", 32'(bus.dsp_prd), 0);
    chk("t6_ready_rst", 32'(bus.dec_ready), 0);
    chk("t6_perf_rst", perf_rename_cnt, 0);
    step(); step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      step();
      bus.dec_valid    = ($urandom_range(0, 3) != 0);
      bus.dec_regwrite = ($urandom_range(0, 9) < 7);
      bus.dec_rd       = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
      bus.dec_rs1      = AW'($urandom_range(0, 31));
      bus.dec_rs2      = AW'($urandom_range(0, 31));
      bus.rt_phy_rs1   = PW'($urandom_range(0, 63));
      bus.rt_phy_rs2   = PW'($urandom_range(0, 63));
      bus.rt_phy_rd    = PW'($urandom_range(0, 63));
      bus.rt_valid     = ($urandom_range(0, 9) < 7);
      bus.dsp_ready    = ($urandom_range(0, 9) < 7);
      flush            = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
